valu_array: RTL and testbench

- Parametrised multi-lane vector ALU for the v_lane datapath. Successor to the fixed 4-interface ALU wrapper.
- Generalised lane count and pipeline depth. Self-contained per-lane opcode decode and SEW-aware arithmetic.
- Adds in-pipeline stall/flush handling, a busy indicator, and per-lane valid/mask tracking.
- Sits between the lane operand-fetch stage and the VRF write-back/mask unit.

---
 rtl/valu_array.sv | 228 ++++++++++++++++++++++
 tb/tb_valu_array.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/valu_array.sv
// Multi-lane, SEW-aware vector ALU with a LATENCY-deep stall/flush pipeline per lane.
// Define VALU_SAT_EN for saturating SADD/SSUB and the sat_o output.
module valu_array #(
  parameter int LANES    = 4,
  parameter int OP_WIDTH = 32,
  parameter int LATENCY  = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [1:0]                sew_i,
  input  logic [LANES*5-1:0]        op_i,
  input  logic [LANES*OP_WIDTH-1:0] a_i,
  input  logic [LANES*OP_WIDTH-1:0] b_i,
  input  logic [LANES-1:0]          vld_i,
  input  logic                      stall_i,
  input  logic                      flush_i,
  output logic [LANES*OP_WIDTH-1:0] res_o,
  output logic [LANES-1:0]          vld_o,
  output logic [LANES-1:0]          mask_o,
`ifdef VALU_SAT_EN
  output logic [LANES-1:0]          sat_o,
`endif
  output logic                      busy_o
);

  localparam logic [4:0] OP_ADD  = 5'd0;
  localparam logic [4:0] OP_SUB  = 5'd1;
  localparam logic [4:0] OP_AND  = 5'd2;
  localparam logic [4:0] OP_OR   = 5'd3;
  localparam logic [4:0] OP_XOR  = 5'd4;
  localparam logic [4:0] OP_SLL  = 5'd5;
  localparam logic [4:0] OP_SRL  = 5'd6;
  localparam logic [4:0] OP_SRA  = 5'd7;
  localparam logic [4:0] OP_MIN  = 5'd8;
  localparam logic [4:0] OP_MAX  = 5'd9;
  localparam logic [4:0] OP_MINU = 5'd10;
  localparam logic [4:0] OP_MAXU = 5'd11;
  localparam logic [4:0] OP_SEQ  = 5'd12;
  localparam logic [4:0] OP_SNE  = 5'd13;
  localparam logic [4:0] OP_SLT  = 5'd14;
  localparam logic [4:0] OP_SLTU = 5'd15;
  localparam logic [4:0] OP_MUL  = 5'd16;
  localparam logic [4:0] OP_SADD = 5'd17;
  localparam logic [4:0] OP_SSUB = 5'd18;

  logic [LANES-1:0] lane_busy;

  assign busy_o = |lane_busy;

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      logic [4:0]  op;
      logic [31:0] a_raw, b_raw;
      logic [31:0] a_u, b_u, a_s, b_s;
      logic [4:0]  sh;
      logic [31:0] prod;
      logic [31:0] r;
      logic [31:0] res_rep;
`ifdef VALU_SAT_EN
      logic signed [32:0] sum_s, dif_s, sat_max, sat_min;
      logic               sat_flag;
      logic [LATENCY-1:0] sat_q, sat_d;
`endif
      logic [LATENCY-1:0] vld_q, vld_d;
      logic [LATENCY-1:0] mask_q, mask_d;
      logic [31:0]        res_q [LATENCY];
      logic [31:0]        res_d [LATENCY];

      assign op    = op_i[gi*5 +: 5];
      assign a_raw = a_i[gi*OP_WIDTH +: OP_WIDTH];
      assign b_raw = b_i[gi*OP_WIDTH +: OP_WIDTH];
      assign prod  = a_u * b_u;

      // Operands are normalised to 32 bits (zero- and sign-extended views) so
      // one datapath serves every SEW; the result is re-truncated afterwards.
      always_comb begin
        a_u = a_raw;
        b_u = b_raw;
        a_s = a_raw;
        b_s = b_raw;
        sh  = b_raw[4:0];
`ifdef VALU_SAT_EN
        sat_max = 33'sd2147483647;
`endif
        case (sew_i)
          2'b00: begin
            a_u = {24'b0, a_raw[7:0]};
            b_u = {24'b0, b_raw[7:0]};
            a_s = {{24{a_raw[7]}}, a_raw[7:0]};
            b_s = {{24{b_raw[7]}}, b_raw[7:0]};
            sh  = {2'b0, b_raw[2:0]};
`ifdef VALU_SAT_EN
            sat_max = 33'sd127;
`endif
          end
          2'b01: begin
            a_u = {16'b0, a_raw[15:0]};
            b_u = {16'b0, b_raw[15:0]};
            a_s = {{16{a_raw[15]}}, a_raw[15:0]};
            b_s = {{16{b_raw[15]}}, b_raw[15:0]};
            sh  = {1'b0, b_raw[3:0]};
`ifdef VALU_SAT_EN
            sat_max = 33'sd32767;
`endif
          end
          default: ;
        endcase
`ifdef VALU_SAT_EN
        sat_min  = -sat_max - 33'sd1;
        sum_s    = $signed({a_s[31], a_s}) + $signed({b_s[31], b_s});
        dif_s    = $signed({a_s[31], a_s}) - $signed({b_s[31], b_s});
        sat_flag = 1'b0;
`endif
        r = '0;
        case (op)
          OP_ADD:  r = a_u + b_u;
          OP_SUB:  r = a_u - b_u;
          OP_AND:  r = a_u & b_u;
          OP_OR:   r = a_u | b_u;
          OP_XOR:  r = a_u ^ b_u;
          OP_SLL:  r = a_u << sh;
          OP_SRL:  r = a_u >> sh;
          OP_SRA:  r = $signed(a_s) >>> sh;
          OP_MIN:  r = ($signed(a_s) < $signed(b_s)) ? a_s : b_s;
          OP_MAX:  r = ($signed(a_s) < $signed(b_s)) ? b_s : a_s;
          OP_MINU: r = (a_u < b_u) ? a_u : b_u;
          OP_MAXU: r = (a_u < b_u) ? b_u : a_u;
          OP_SEQ:  r = {31'b0, a_u == b_u};
          OP_SNE:  r = {31'b0, a_u != b_u};
          OP_SLT:  r = {31'b0, $signed(a_s) < $signed(b_s)};
          OP_SLTU: r = {31'b0, a_u < b_u};
          OP_MUL:  r = prod;
`ifdef VALU_SAT_EN
          OP_SADD: begin
            if (sum_s > sat_max) begin
              r = sat_max[31:0];
              sat_flag = 1'b1;
            end else if (sum_s < sat_min) begin
              r = sat_min[31:0];
              sat_flag = 1'b1;
            end else begin
              r = sum_s[31:0];
            end
          end
          OP_SSUB: begin
            if (dif_s > sat_max) begin
              r = sat_max[31:0];
              sat_flag = 1'b1;
            end else if (dif_s < sat_min) begin
              r = sat_min[31:0];
              sat_flag = 1'b1;
            end else begin
              r = dif_s[31:0];
            end
          end
`else
          OP_SADD: r = a_u + b_u;
          OP_SSUB: r = a_u - b_u;
`endif
          default: r = '0;
        endcase
        case (sew_i)
          2'b00:   res_rep = {4{r[7:0]}};
          2'b01:   res_rep = {2{r[15:0]}};
          default: res_rep = r;
        endcase
      end

      // Flush overrides stall; stall freezes every stage including the output.
      always_comb begin
        vld_d  = vld_q;
        mask_d = mask_q;
        res_d  = res_q;
`ifdef VALU_SAT_EN
        sat_d  = sat_q;
`endif
        if (flush_i) begin
          vld_d = '0;
        end else if (!stall_i) begin
          vld_d[0] = vld_i[gi];
          if (vld_i[gi]) begin
            res_d[0]  = res_rep;
            mask_d[0] = res_rep[0];
`ifdef VALU_SAT_EN
            sat_d[0]  = sat_flag;
`endif
          end
          for (int s = 1; s < LATENCY; s++) begin
            vld_d[s]  = vld_q[s-1];
            mask_d[s] = mask_q[s-1];
            res_d[s]  = res_q[s-1];
`ifdef VALU_SAT_EN
            sat_d[s]  = sat_q[s-1];
`endif
          end
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          vld_q  <= '0;
          mask_q <= '0;
          for (int s = 0; s < LATENCY; s++) res_q[s] <= '0;
`ifdef VALU_SAT_EN
          sat_q  <= '0;
`endif
        end else begin
          vld_q  <= vld_d;
          mask_q <= mask_d;
          res_q  <= res_d;
`ifdef VALU_SAT_EN
          sat_q  <= sat_d;
`endif
        end
      end

      assign res_o[gi*OP_WIDTH +: OP_WIDTH] = res_q[LATENCY-1];
      assign vld_o[gi]     = vld_q[LATENCY-1];
      assign mask_o[gi]    = mask_q[LATENCY-1];
      assign lane_busy[gi] = |vld_q;
`ifdef VALU_SAT_EN
      assign sat_o[gi]     = sat_q[LATENCY-1];
`endif
    end
  endgenerate

endmodule

// File: tb/tb_valu_array.sv
// Directed-vector bench for valu_array (LANES=4, LATENCY=2); honours VALU_SAT_EN.
module tb_valu_array;
  localparam int LANES = 4;
  localparam int W     = 32;

  logic               clk = 1'b0;
  logic               rst;
  logic [1:0]         sew_i;
  logic [LANES*5-1:0] op_i;
  logic [LANES*W-1:0] a_i, b_i;
  logic [LANES-1:0]   vld_i;
  logic               stall_i, flush_i;
  logic [LANES*W-1:0] res_o;
  logic [LANES-1:0]   vld_o, mask_o;
  logic               busy_o;
`ifdef VALU_SAT_EN
  logic [LANES-1:0]   sat_o;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  valu_array #(.LANES(LANES), .OP_WIDTH(W), .LATENCY(2)) dut (
    .clk(clk), .rst(rst), .sew_i(sew_i), .op_i(op_i), .a_i(a_i), .b_i(b_i),
    .vld_i(vld_i), .stall_i(stall_i), .flush_i(flush_i),
    .res_o(res_o), .vld_o(vld_o), .mask_o(mask_o),
`ifdef VALU_SAT_EN
    .sat_o(sat_o),
`endif
    .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    vld_i = '0; stall_i = 1'b0; flush_i = 1'b0;
  endtask

  task automatic set_lane(input int l, input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    op_i[l*5 +: 5] = op;
    a_i[l*W +: W]  = a;
    b_i[l*W +: W]  = b;
  endtask

  function automatic logic [31:0] lane_res(input int l);
    return res_o[l*W +: W];
  endfunction

  task automatic test_reset();
    rst = 1'b1; sew_i = 2'b10; op_i = '0; a_i = '0; b_i = '0;
    idle();
    step(); step();
    n_cmp++; if (res_o !== '0) begin n_bad++; $display("FAIL reset_res got=%h want=0", res_o); end
    n_cmp++; if (vld_o !== 4'b0) begin n_bad++; $display("FAIL reset_vld got=%b want=0000", vld_o); end
    n_cmp++; if (mask_o !== 4'b0) begin n_bad++; $display("FAIL reset_mask got=%b want=0000", mask_o); end
    n_cmp++; if (busy_o !== 1'b0) begin n_bad++; $display("FAIL reset_busy got=%b want=0", busy_o); end
    rst = 1'b0;
    step();
    n_cmp++; if (vld_o !== 4'b0 || busy_o !== 1'b0) begin n_bad++; $display("FAIL reset_release vld=%b busy=%b want 0000/0", vld_o, busy_o); end
    $display("txn reset done");
  endtask

  task automatic test_add32();
    idle(); sew_i = 2'b10;
    set_lane(0, 5'd0, 32'h7FFF_FFFF, 32'h0000_0001);
    vld_i = 4'b0001;
    step();
    idle();
    n_cmp++; if (vld_o[0] !== 1'b0) begin n_bad++; $display("FAIL add32_early vld got=%b want=0", vld_o[0]); end
    n_cmp++; if (busy_o !== 1'b1) begin n_bad++; $display("FAIL add32_busy got=%b want=1", busy_o); end
    step();
    n_cmp++; if (vld_o !== 4'b0001) begin n_bad++; $display("FAIL add32_vld got=%b want=0001", vld_o); end
    n_cmp++; if (lane_res(0) !== 32'h8000_0000) begin n_bad++; $display("FAIL add32_res got=%h want=80000000", lane_res(0)); end
    n_cmp++; if (mask_o[0] !== 1'b0) begin n_bad++; $display("FAIL add32_mask got=%b want=0", mask_o[0]); end
    step();
    n_cmp++; if (vld_o !== 4'b0 || busy_o !== 1'b0) begin n_bad++; $display("FAIL add32_drain vld=%b busy=%b want 0000/0", vld_o, busy_o); end
    $display("txn add32 lane0 res=%h", 32'h8000_0000);
  endtask

  task automatic test_sew_mix();
    logic [31:0] exp_a [LANES];
    logic [31:0] exp_b [LANES];
    exp_a = '{32'hC0C0_C0C0, 32'hFEFE_FEFE, 32'hF0F0_F0F0, 32'h1010_1010};
    exp_b = '{32'h3400_3400, 32'h0001_0001, 32'h0000_0000, 32'h0008_0008};
    idle(); sew_i = 2'b00;
    set_lane(0, 5'd7,  32'h0000_0080, 32'h0000_0009);
    set_lane(1, 5'd1,  32'h0000_0003, 32'h0000_0005);
    set_lane(2, 5'd11, 32'h0000_0010, 32'h0000_00F0);
    set_lane(3, 5'd9,  32'h0000_0010, 32'h0000_00F0);
    vld_i = 4'b1111;
    step();
    sew_i = 2'b01;
    set_lane(0, 5'd16, 32'h0000_1234, 32'h0000_0100);
    set_lane(1, 5'd14, 32'h0000_FFFF, 32'h0000_0001);
    set_lane(2, 5'd20, 32'h0000_1111, 32'h0000_2222);
    set_lane(3, 5'd5,  32'hABCD_0001, 32'h0000_0013);
    step();
    idle();
    n_cmp++; if (vld_o !== 4'b1111) begin n_bad++; $display("FAIL sew8_vld got=%b want=1111", vld_o); end
    n_cmp++; if (mask_o !== 4'b0000) begin n_bad++; $display("FAIL sew8_mask got=%b want=0000", mask_o); end
    for (int l = 0; l < LANES; l++) begin
      n_cmp++;
      if (lane_res(l) !== exp_a[l]) begin n_bad++; $display("FAIL sew8_res lane%0d got=%h want=%h", l, lane_res(l), exp_a[l]); end
    end
    $display("txn sew8 ops res=%h", res_o);
    step();
    n_cmp++; if (vld_o !== 4'b1111) begin n_bad++; $display("FAIL sew16_vld got=%b want=1111", vld_o); end
    n_cmp++; if (mask_o !== 4'b0010) begin n_bad++; $display("FAIL sew16_mask got=%b want=0010", mask_o); end
    for (int l = 0; l < LANES; l++) begin
      n_cmp++;
      if (lane_res(l) !== exp_b[l]) begin n_bad++; $display("FAIL sew16_res lane%0d got=%h want=%h", l, lane_res(l), exp_b[l]); end
    end
    $display("txn sew16 ops res=%h", res_o);
    step();
  endtask

  task automatic test_back_to_back();
    idle(); sew_i = 2'b10;
    set_lane(2, 5'd16, 32'h0000_0003, 32'h0000_0005);
    vld_i = 4'b0100;
    step();
    n_cmp++; if (vld_o[2] !== 1'b0) begin n_bad++; $display("FAIL b2b_early vld got=%b want=0", vld_o[2]); end
    set_lane(2, 5'd16, 32'h0001_0000, 32'h0001_0000);
    step();
    n_cmp++; if (vld_o[2] !== 1'b1 || lane_res(2) !== 32'd15 || mask_o[2] !== 1'b1) begin
      n_bad++; $display("FAIL b2b_r1 vld=%b res=%h mask=%b want 1/0000000f/1", vld_o[2], lane_res(2), mask_o[2]); end
    set_lane(2, 5'd16, 32'hFFFF_FFFF, 32'h0000_0002);
    stall_i = 1'b1;
    step();
    n_cmp++; if (vld_o[2] !== 1'b1 || lane_res(2) !== 32'd15) begin
      n_bad++; $display("FAIL b2b_stall_hold vld=%b res=%h want 1/0000000f", vld_o[2], lane_res(2)); end
    stall_i = 1'b0;
    step();
    n_cmp++; if (vld_o[2] !== 1'b1 || lane_res(2) !== 32'h0 || mask_o[2] !== 1'b0) begin
      n_bad++; $display("FAIL b2b_r2 vld=%b res=%h mask=%b want 1/00000000/0", vld_o[2], lane_res(2), mask_o[2]); end
    set_lane(2, 5'd16, 32'h1234_5678, 32'h0000_0010);
    step();
    n_cmp++; if (vld_o[2] !== 1'b1 || lane_res(2) !== 32'hFFFF_FFFE) begin
      n_bad++; $display("FAIL b2b_r3 vld=%b res=%h want 1/fffffffe", vld_o[2], lane_res(2)); end
    idle();
    step();
    n_cmp++; if (vld_o !== 4'b0100 || lane_res(2) !== 32'h2345_6780) begin
      n_bad++; $display("FAIL b2b_r4 vld=%b res=%h want 0100/23456780", vld_o, lane_res(2)); end
    step();
    n_cmp++; if (vld_o !== 4'b0 || busy_o !== 1'b0) begin n_bad++; $display("FAIL b2b_drain vld=%b busy=%b want 0000/0", vld_o, busy_o); end
    $display("txn back_to_back lane2 4 MULs");
  endtask

  task automatic test_flush();
    idle(); sew_i = 2'b10;
    set_lane(0, 5'd0, 32'd1, 32'd1);
    set_lane(1, 5'd0, 32'd2, 32'd2);
    vld_i = 4'b0011;
    step();
    n_cmp++; if (busy_o !== 1'b1) begin n_bad++; $display("FAIL flush_busy_pre got=%b want=1", busy_o); end
    vld_i = 4'b1111; stall_i = 1'b1; flush_i = 1'b1;
    step();
    idle();
    n_cmp++; if (busy_o !== 1'b0) begin n_bad++; $display("FAIL flush_busy got=%b want=0", busy_o); end
    for (int c = 0; c < 3; c++) begin
      n_cmp++; if (vld_o !== 4'b0) begin n_bad++; $display("FAIL flush_vld cyc%0d got=%b want=0000", c, vld_o); end
      step();
    end
    $display("txn flush dropped 2 ops");
  endtask

  task automatic test_sat();
    logic [31:0] exp_r [LANES];
`ifdef VALU_SAT_EN
    exp_r = '{32'h7F7F_7F7F, 32'h8080_8080, 32'h3030_3030, 32'hFEFE_FEFE};
`else
    exp_r = '{32'h8080_8080, 32'h7F7F_7F7F, 32'h3030_3030, 32'hFEFE_FEFE};
`endif
    idle(); sew_i = 2'b00;
    set_lane(0, 5'd17, 32'h0000_007F, 32'h0000_0001);
    set_lane(1, 5'd18, 32'h0000_0080, 32'h0000_0001);
    set_lane(2, 5'd17, 32'h0000_0010, 32'h0000_0020);
    set_lane(3, 5'd18, 32'h0000_0005, 32'h0000_0007);
    vld_i = 4'b1111;
    step();
    idle();
    step();
    n_cmp++; if (vld_o !== 4'b1111) begin n_bad++; $display("FAIL sat_vld got=%b want=1111", vld_o); end
    for (int l = 0; l < LANES; l++) begin
      n_cmp++;
      if (lane_res(l) !== exp_r[l]) begin n_bad++; $display("FAIL sat_res lane%0d got=%h want=%h", l, lane_res(l), exp_r[l]); end
    end
`ifdef VALU_SAT_EN
    n_cmp++; if (sat_o !== 4'b0011) begin n_bad++; $display("FAIL sat_flag got=%b want=0011", sat_o); end
`endif
    $display("txn sadd/ssub res=%h", res_o);
    step();
  endtask

  task automatic test_async_reset();
    idle(); sew_i = 2'b10;
    for (int l = 0; l < LANES; l++) set_lane(l, 5'd0, 32'(l + 1), 32'h0000_0100);
    vld_i = 4'b1111;
    step();
    step();
    vld_i = '0;
    n_cmp++; if (vld_o !== 4'b1111 || busy_o !== 1'b1) begin n_bad++; $display("FAIL arst_pre vld=%b busy=%b want 1111/1", vld_o, busy_o); end
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (vld_o !== 4'b0 || busy_o !== 1'b0) begin n_bad++; $display("FAIL arst_vld vld=%b busy=%b want 0000/0", vld_o, busy_o); end
    n_cmp++; if (res_o !== '0 || mask_o !== 4'b0) begin n_bad++; $display("FAIL arst_res res=%h mask=%b want 0/0000", res_o, mask_o); end
    #1 rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      n_cmp++; if (vld_o !== 4'b0 || busy_o !== 1'b0) begin n_bad++; $display("FAIL arst_after cyc%0d vld=%b busy=%b want 0000/0", c, vld_o, busy_o); end
    end
    $display("txn async reset mid-flight");
  endtask

  initial begin
    test_reset();
    test_add32();
    test_sew_mix();
    test_back_to_back();
    test_flush();
    test_sat();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
